// File: rtl/key_debounce3.sv
// Three-channel key conditioner: 2-flop synchroniser, per-key debounce FSM,
// clean pressed level plus registered one-cycle press/release pulses.
module key_debounce3 #(
  parameter int   CNT_MAX    = 1_000_000,
  parameter logic KEY_ACTIVE = 1'b1
) (
  input  logic       CLK_50M,
  input  logic       RST_N,
  input  logic [2:0] KEY_IN,
  output logic [2:0] KEY_OUT,
  output logic [2:0] KEY_PRESS,
  output logic [2:0] KEY_RELEASE
);

  localparam int CNT_W = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic [2:0] key_p0;
  logic [2:0] key_p1;
  logic [2:0] pressed_p1;

  // Stage p0/p1: synchroniser, reset to the idle pin level so no false press
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      key_p0 <= {3{~KEY_ACTIVE}};
      key_p1 <= {3{~KEY_ACTIVE}};
    end else begin
      key_p0 <= KEY_IN;
      key_p1 <= key_p0;
    end
  end

  assign pressed_p1 = KEY_ACTIVE ? key_p1 : ~key_p1;

  // Stage p2: independent debounce FSM per key
  for (genvar i = 0; i < 3; i++) begin : g_ch
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             out_p2;
    logic             press_p2;
    logic             release_p2;

    always_ff @(posedge CLK_50M or negedge RST_N) begin
      if (!RST_N) begin
        state      <= RELEASED;
        cnt        <= '0;
        out_p2     <= 1'b0;
        press_p2   <= 1'b0;
        release_p2 <= 1'b0;
      end else begin
        press_p2   <= 1'b0;
        release_p2 <= 1'b0;
        case (state)
          RELEASED: begin
            cnt <= '0;
            if (pressed_p1[i]) begin
              state <= PRESS_WAIT;
              cnt   <= CNT_ONE;
            end
          end
          PRESS_WAIT: begin
            if (!pressed_p1[i]) begin
              state <= RELEASED;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state    <= PRESSED;
              cnt      <= '0;
              out_p2   <= 1'b1;
              press_p2 <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          PRESSED: begin
            cnt <= '0;
            if (!pressed_p1[i]) begin
              state <= RELEASE_WAIT;
              cnt   <= CNT_ONE;
            end
          end
          RELEASE_WAIT: begin
            if (pressed_p1[i]) begin
              state <= PRESSED;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state      <= RELEASED;
              cnt        <= '0;
              out_p2     <= 1'b0;
              release_p2 <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state <= RELEASED;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign KEY_OUT[i]     = out_p2;
    assign KEY_PRESS[i]   = press_p2;
    assign KEY_RELEASE[i] = release_p2;
  end

endmodule

// File: tb/tb_key_debounce3.sv
// Bench for key_debounce3: run-length debounce model checked every cycle,
// plus directed scenarios with hand-computed cycle positions.
module tb_key_debounce3;

  localparam int CNT = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] key_in = 3'b000;
  logic [2:0] key_out, key_press, key_release;

  key_debounce3 #(.CNT_MAX(CNT), .KEY_ACTIVE(1'b1)) dut (
    .CLK_50M    (clk),
    .RST_N      (rst_n),
    .KEY_IN     (key_in),
    .KEY_OUT    (key_out),
    .KEY_PRESS  (key_press),
    .KEY_RELEASE(key_release)
  );

  always #5 clk = ~clk;

  // Model: a level flips after CNT consecutive synchronised samples that disagree with it
  logic [2:0] m_p0, m_p1, m_s, m_out, m_press, m_rel;
  int run [3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_p0 = 3'b000; m_p1 = 3'b000;
      m_out = 3'b000; m_press = 3'b000; m_rel = 3'b000;
      for (int i = 0; i < 3; i++) run[i] = 0;
    end else begin
      m_s = m_p1;
      m_p1 = m_p0;
      m_p0 = key_in;
      m_press = 3'b000;
      m_rel = 3'b000;
      for (int i = 0; i < 3; i++) begin
        if (m_s[i] != m_out[i]) begin
          run[i] = run[i] + 1;
          if (run[i] == CNT) begin
            run[i] = 0;
            m_out[i] = m_s[i];
            if (m_s[i]) m_press[i] = 1'b1;
            else        m_rel[i] = 1'b1;
          end
        end else begin
          run[i] = 0;
        end
      end
    end
  end

  int tests = 0;
  int fails = 0;
  int press_seen [3];

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (key_press[i] === 1'b1) press_seen[i]++;
      chk("model", {key_out, key_press, key_release}, {m_out, m_press, m_rel});
    end
  endtask

  function automatic logic [8:0] outs();
    return {key_out, key_press, key_release};
  endfunction

  int base;

  initial begin
    for (int i = 0; i < 3; i++) press_seen[i] = 0;
    key_in = 3'b111;
    #1 rst_n = 1'b0;
    step(3);
    chk("reset_outputs", outs(), 9'b000_000_000);
    rst_n = 1'b1;
    step(9);
    chk("reset_pre_press", outs(), 9'b000_000_000);
    step(1);
    chk("reset_fresh_press", outs(), 9'b111_111_000);
    step(1);
    chk("reset_press_one_cycle", outs(), 9'b111_000_000);

    key_in = 3'b000;
    step(9);
    chk("all_release_pending", outs(), 9'b111_000_000);
    step(1);
    chk("all_release", outs(), 9'b000_000_111);
    step(5);

    // Clean press/release on KEY1
    key_in[0] = 1'b1;
    step(9);
    chk("key1_not_yet", outs(), 9'b000_000_000);
    step(1);
    chk("key1_press", outs(), 9'b001_001_000);
    step(20);
    chk("key1_held", outs(), 9'b001_000_000);
    key_in[0] = 1'b0;
    step(9);
    chk("key1_release_pending", outs(), 9'b001_000_000);
    step(1);
    chk("key1_release", outs(), 9'b000_000_001);
    step(5);

    // Glitch rejection on KEY2: 7 high cycles rejected, 8 accepted
    base = press_seen[1];
    key_in[1] = 1'b1;
    step(7);
    key_in[1] = 1'b0;
    step(20);
    chk("glitch7_out", outs(), 9'b000_000_000);
    chk("glitch7_no_press", 9'(press_seen[1] - base), 9'd0);
    key_in[1] = 1'b1;
    step(8);
    key_in[1] = 1'b0;
    step(3);
    chk("glitch8_press", 9'(press_seen[1] - base), 9'd1);
    step(20);
    chk("glitch8_released", outs(), 9'b000_000_000);

    // Bounce on KEY3: 1,0,1,0 then held high
    base = press_seen[2];
    key_in[2] = 1'b1; step(1);
    key_in[2] = 1'b0; step(1);
    key_in[2] = 1'b1; step(1);
    key_in[2] = 1'b0; step(1);
    key_in[2] = 1'b1;
    step(9);
    chk("bounce_not_yet", outs(), 9'b000_000_000);
    step(1);
    chk("bounce_press", outs(), 9'b100_100_000);
    step(10);
    chk("bounce_single_press", 9'(press_seen[2] - base), 9'd1);
    key_in[2] = 1'b0;
    step(15);

    // Simultaneous press, staggered release
    key_in = 3'b111;
    step(10);
    chk("simul_press", outs(), 9'b111_111_000);
    step(1);
    chk("simul_press_end", outs(), 9'b111_000_000);
    step(5);
    key_in[0] = 1'b0; step(3);
    key_in[1] = 1'b0; step(3);
    key_in[2] = 1'b0;
    step(4);
    chk("stagger_rel0", outs(), 9'b110_000_001);
    step(3);
    chk("stagger_rel1", outs(), 9'b100_000_010);
    step(3);
    chk("stagger_rel2", outs(), 9'b000_000_100);
    step(5);

    // Reset at count 5 of a KEY1 press
    base = press_seen[0];
    key_in[0] = 1'b1;
    step(7);
    rst_n = 1'b0;
    step(2);
    chk("midreset_outputs", outs(), 9'b000_000_000);
    rst_n = 1'b1;
    step(9);
    chk("midreset_no_press", 9'(press_seen[0] - base), 9'd0);
    step(1);
    chk("midreset_fresh_press", outs(), 9'b001_001_000);
    step(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/key_debounce3.md
# key_debounce3

Three-channel key conditioner between the raw KEY1..KEY3 board pins and the three-voter logic. Each key is synchronised to CLK_50M and debounced with a per-key counter. The block drives a clean pressed level per key plus one-cycle press and release pulses. The voter consumes KEY_OUT in place of raw pins; the pulses are for counting or latching logic.

## Interface
- CNT_MAX, 1_000_000: consecutive stable cycles required to accept a level change (20 ms at 50 MHz). Legal range 2 .. 2^24.
- KEY_ACTIVE, 1'b1: raw pin level that means "pressed". All outputs are active-high regardless of this setting.
- CLK_50M  in  1  system clock; the only clock.
- RST_N  in  1  reset, asynchronous assert, active-low.
- KEY_IN  in  [2:0]  raw keys; bit0 = KEY1, bit1 = KEY2, bit2 = KEY3; asynchronous to CLK_50M.
- KEY_OUT  out  [2:0]  debounced level per key; 1 = pressed.
- KEY_PRESS  out  [2:0]  one-cycle pulse when KEY_OUT bit rises.
- KEY_RELEASE  out  [2:0]  one-cycle pulse when KEY_OUT bit falls.

## Operation
- Input stage
  - Each bit passes through a 2-flop synchroniser.
  - The synchroniser output is converted to pressed-high: `s = (sync == KEY_ACTIVE)`.
- Per-channel state machine (three identical, fully independent instances):
  - RELEASED: KEY_OUT = 0, counter held at 0. If s = 1, go to PRESS_WAIT with the counter at 1.
  - PRESS_WAIT: if s = 0, return to RELEASED and clear the counter (glitch rejected). If s = 1 and the counter = CNT_MAX-1, go to PRESSED, clear the counter and pulse KEY_PRESS. Otherwise increment the counter.
  - PRESSED: KEY_OUT = 1, counter held at 0. If s = 0, go to RELEASE_WAIT with the counter at 1.
  - RELEASE_WAIT: mirror of PRESS_WAIT. s = 1 returns to PRESSED with the counter cleared. CNT_MAX consecutive s = 0 samples move to RELEASED and pulse KEY_RELEASE.
- Counter
  - Width is clog2(CNT_MAX), unsigned.
  - It never exceeds CNT_MAX-1 and never wraps.
- Output encoding
  - KEY_OUT is 1 exactly in PRESSED and RELEASE_WAIT.
  - KEY_PRESS and KEY_RELEASE are registered and asserted for exactly one cycle per accepted transition.
  - KEY_PRESS and KEY_RELEASE are never both high on the same bit.
- Reset (RST_N low)
  - Synchroniser flops load the inactive level (~KEY_ACTIVE).
  - All channels enter RELEASED; all counters are 0.
  - KEY_OUT = 3'b000, KEY_PRESS = 3'b000, KEY_RELEASE = 3'b000.
  - A reset during any WAIT state aborts it with no pulse.
- A key held through reset is reported as a fresh press after reset deasserts.

## Timing
- Accepted edge latency: a raw edge captured at clock edge N is followed by KEY_OUT and the pulse changing at edge N+2+CNT_MAX-1 (2 synchroniser cycles + CNT_MAX qualifying samples), provided the level holds throughout.
- Rejection window: any excursion shorter than CNT_MAX samples (at the synchroniser output) produces no output change and no pulse.
- Bounce: bounce inside the window restarts qualification from 1 on the next opposite sample.
- Simultaneous events: keys changing on the same cycle are processed independently. Multiple KEY_PRESS bits may be high on the same cycle.
- Minimum spacing: consecutive KEY_PRESS pulses on one bit are at least 2·CNT_MAX cycles apart.
- Reset deassertion: synchronous to the board reset synchroniser. The first state change is possible no earlier than CNT_MAX+2 cycles after RST_N rises.

## Test plan
All scenarios use CNT_MAX = 8 and KEY_ACTIVE = 1.
- Reset values: hold RST_N low with KEY_IN = 3'b111 -> all outputs 0. Release reset -> KEY_OUT = 3'b111 and KEY_PRESS = 3'b111 for one cycle, exactly 9 cycles after the first post-reset sampling edge. No KEY_RELEASE.
- Clean press and release on KEY1: KEY_IN[0] rises at edge 10 -> KEY_OUT[0] = 1 and KEY_PRESS[0] pulse at edge 19. KEY_IN[0] falls at edge 40 -> KEY_OUT[0] = 0 and KEY_RELEASE[0] pulse at edge 49. Other bits stay 0 throughout.
- Glitch rejection: KEY_IN[1] high for 7 cycles then low -> no change on any output. The same stimulus with 8 high cycles -> one KEY_PRESS[1].
- Bounce: KEY_IN[2] toggles 1,0,1,0,1 on single cycles, then holds high -> exactly one KEY_PRESS[2], 8 cycles after the final rising sample reaches the synchroniser output.
- Simultaneous keys: all three bits rise on the same edge -> KEY_PRESS = 3'b111 for one cycle. Staggered releases 3 cycles apart -> three separate single-bit KEY_RELEASE pulses, 3 cycles apart.
- Reset mid-qualification: RST_N pulsed low at count 5 of a KEY1 press -> no KEY_PRESS[0]. After release with the key still held, a fresh press is reported 9 cycles later.
